// File: rtl/seq_stage_controller.sv
// -----------------------------------------------------------------------------
// seq_stage_controller
//
// Multi-cycle sequencer for the Y86-64 SEQ datapath. Walks one instruction at
// a time through FETCH, DECODE, EXECUTE, [MEMORY], [WRITEBACK], PCUPD and
// raises exactly one registered stage strobe per cycle. MEMORY is skipped for
// instructions that never touch data memory, and WRITEBACK is skipped for
// instructions that write no register. The register file uses writeback_en as
// its write strobe.
//
// Processor status (stat): 1=AOK, 2=HLT, 3=ADR, 4=INS. Any non-AOK status
// parks the sequencer in HALT until reset.
//
// Parameters:
//   MEM_TIMEOUT  cycles allowed in MEMORY without mem_ready before ADR.
//   CNT_W        width of cycle_count and instr_count.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   start         leave IDLE and begin fetching (ignored outside IDLE)
//   step          (SEQ_SINGLE_STEP_EN only) run exactly one instruction
//   icode         instruction code from fetch, sampled at end of FETCH
//   instr_valid   fetch decoded a legal icode/ifun, sampled at end of FETCH
//   imem_error    fetch address out of range, sampled at end of FETCH
//   dmem_error    data-memory address error, sampled in MEMORY with mem_ready
//   mem_ready     data memory has completed its access
//   fetch_en .. pc_update_en   one-hot registered stage strobes
//   stat          processor status code
//   halted        high while in HALT
//   cycle_count   cycles spent in FETCH..PCUPD (wraps)
//   instr_count   completed PC updates (wraps)
//
// Optional feature (define SEQ_SINGLE_STEP_EN):
//   Adds the step input. PCUPD returns to IDLE instead of FETCH, and either
//   start or step launches exactly one instruction from IDLE.
// -----------------------------------------------------------------------------
module seq_stage_controller #(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_error,
    input  logic             mem_ready,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic             pc_update_en,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] DECODE    = 3'd2;
    localparam logic [2:0] EXECUTE   = 3'd3;
    localparam logic [2:0] MEMORY    = 3'd4;
    localparam logic [2:0] WRITEBACK = 3'd5;
    localparam logic [2:0] PCUPD     = 3'd6;
    localparam logic [2:0] HALT      = 3'd7;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam int             TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [2:0]      state;
    logic [2:0]      nextState;
    logic [2:0]      nextStat;
    logic [3:0]      icodeReg;
    logic [TO_W-1:0] memWait;
    logic            goFetch;
    logic            usesMem;
    logic            execToWb;
    logic            memToWb;

`ifdef SEQ_SINGLE_STEP_EN
    assign goFetch = start | step;
`else
    assign goFetch = start;
`endif

    // Stage routing is decided from the icode captured at the end of FETCH,
    // so the fetch unit is free to move on after that cycle.
    // mrmovq/rmmovq/call/ret/push/pop reach data memory.
    assign usesMem  = icodeReg inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    // cmovXX/irmovq/OPq write a register without touching memory.
    assign execToWb = icodeReg inside {4'h2, 4'h3, 4'h6};
    // Everything memory-bound except rmmovq also writes a register.
    assign memToWb  = icodeReg inside {4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        nextState = state;
        nextStat  = stat;
        case (state)
            IDLE: begin
                if (goFetch) nextState = FETCH;
            end
            FETCH: begin
                if (imem_error) begin
                    nextState = HALT;
                    nextStat  = STAT_ADR;
                end else if (!instr_valid) begin
                    nextState = HALT;
                    nextStat  = STAT_INS;
                end else if (icode == 4'h0) begin
                    nextState = HALT;
                    nextStat  = STAT_HLT;
                end else begin
                    nextState = DECODE;
                end
            end
            DECODE: nextState = EXECUTE;
            EXECUTE: begin
                if (usesMem)       nextState = MEMORY;
                else if (execToWb) nextState = WRITEBACK;
                else               nextState = PCUPD;
            end
            MEMORY: begin
                if (mem_ready) begin
                    if (dmem_error) begin
                        nextState = HALT;
                        nextStat  = STAT_ADR;
                    end else begin
                        nextState = memToWb ? WRITEBACK : PCUPD;
                    end
                end else if (memWait == TO_LAST) begin
                    // Last allowed cycle without ready: treat as a bad address.
                    nextState = HALT;
                    nextStat  = STAT_ADR;
                end
            end
            WRITEBACK: nextState = PCUPD;
            PCUPD: begin
`ifdef SEQ_SINGLE_STEP_EN
                nextState = IDLE;
`else
                nextState = FETCH;
`endif
            end
            HALT:    nextState = HALT;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state        <= IDLE;
            stat         <= STAT_AOK;
            halted       <= 1'b0;
            fetch_en     <= 1'b0;
            decode_en    <= 1'b0;
            execute_en   <= 1'b0;
            memory_en    <= 1'b0;
            writeback_en <= 1'b0;
            pc_update_en <= 1'b0;
            icodeReg     <= 4'h0;
            memWait      <= '0;
            cycle_count  <= '0;
            instr_count  <= '0;
        end else begin
            state  <= nextState;
            stat   <= nextStat;
            // Strobes are registered decodes of the next state, so each one
            // is high for exactly the cycle its state is occupied.
            halted       <= (nextState == HALT);
            fetch_en     <= (nextState == FETCH);
            decode_en    <= (nextState == DECODE);
            execute_en   <= (nextState == EXECUTE);
            memory_en    <= (nextState == MEMORY);
            writeback_en <= (nextState == WRITEBACK);
            pc_update_en <= (nextState == PCUPD);

            if (state == FETCH) icodeReg <= icode;

            // Held at zero outside MEMORY, so it is already clear on entry.
            if (state == MEMORY && !mem_ready) memWait <= memWait + TO_W'(1);
            else                               memWait <= '0;

            if (state != IDLE && state != HALT) cycle_count <= cycle_count + CNT_W'(1);
            if (state == PCUPD)                 instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_stage_controller.sv
// -----------------------------------------------------------------------------
// tb_seq_stage_controller
//
// Directed bench for seq_stage_controller. Each scenario is described as a
// list of instructions; a model expands every instruction into the stage
// sequence it must take (from its icode class, memory wait and error flags)
// together with the input values for each cycle and the expected status and
// counters. One loop drives those inputs and compares every output on every
// cycle; a few literal expectations pin the model's arithmetic.
// Build with +define+SEQ_SINGLE_STEP_EN to exercise the single-step variant.
// -----------------------------------------------------------------------------
module tb_seq_stage_controller;

    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 32;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE,
        ST_MEMORY, ST_WRITEBACK, ST_PCUPD, ST_HALT
    } stage_e;

    typedef struct {
        stage_e      stage;
        logic        start;
        logic        step;
        logic [3:0]  icode;
        logic        valid;
        logic        imemErr;
        logic        memReady;
        logic        dmemErr;
        logic [2:0]  stat;
        logic [31:0] cyc;
        logic [31:0] ins;
    } rec_t;

    logic             clk;
    logic             reset;
    logic             start;
`ifdef SEQ_SINGLE_STEP_EN
    logic             step;
`endif
    logic [3:0]       icode;
    logic             instr_valid;
    logic             imem_error;
    logic             dmem_error;
    logic             mem_ready;
    logic             fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_update_en;
    logic [2:0]       stat;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    int tests = 0;
    int fails = 0;

    rec_t        q[$];
    logic [2:0]  mStat;
    logic [31:0] mCyc;
    logic [31:0] mIns;
    int          memSeen, wbSeen, decSeen, pcSeen;

    seq_stage_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
`ifdef SEQ_SINGLE_STEP_EN
        .step         (step),
`endif
        .icode        (icode),
        .instr_valid  (instr_valid),
        .imem_error   (imem_error),
        .dmem_error   (dmem_error),
        .mem_ready    (mem_ready),
        .fetch_en     (fetch_en),
        .decode_en    (decode_en),
        .execute_en   (execute_en),
        .memory_en    (memory_en),
        .writeback_en (writeback_en),
        .pc_update_en (pc_update_en),
        .stat         (stat),
        .halted       (halted),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    task automatic beginScenario();
        q.delete();
        mStat   = 3'd1;
        mCyc    = 0;
        mIns    = 0;
        memSeen = 0;
        wbSeen  = 0;
        decSeen = 0;
        pcSeen  = 0;
    endtask

    task automatic push(input stage_e st, input logic startV, input logic stepV,
                        input logic [3:0] ic, input logic v, input logic ie,
                        input logic mr, input logic de);
        rec_t r;
        r.stage    = st;
        r.start    = startV;
        r.step     = stepV;
        r.icode    = ic;
        r.valid    = v;
        r.imemErr  = ie;
        r.memReady = mr;
        r.dmemErr  = de;
        r.stat     = mStat;
        r.cyc      = mCyc;
        r.ins      = mIns;
        q.push_back(r);
        if (st != ST_IDLE && st != ST_HALT) mCyc++;
        if (st == ST_PCUPD) mIns++;
    endtask

    task automatic addIdle(input logic startV, input logic stepV);
        push(ST_IDLE, startV, stepV, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // start/step held high while halted: both must be ignored.
    task automatic addHalt(input int n);
        for (int i = 0; i < n; i++) push(ST_HALT, 1'b1, 1'b1, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    // Single-step builds park in IDLE after every instruction.
    task automatic gap();
`ifdef SEQ_SINGLE_STEP_EN
        addIdle(1'b0, 1'b0);
        addIdle(1'b0, 1'b1);
`endif
    endtask

    // Non-FETCH cycles drive junk fetch inputs so only the latched icode counts.
    task automatic addInstr(input logic [3:0] ic, input logic v, input logic ie,
                            input int memWait, input logic de);
        push(ST_FETCH, 1'b0, 1'b0, ic, v, ie, 1'b1, 1'b0);
        if (ie)          begin mStat = 3'd3; return; end
        if (!v)          begin mStat = 3'd4; return; end
        if (ic == 4'h0)  begin mStat = 3'd2; return; end
        push(ST_DECODE,  1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
        push(ST_EXECUTE, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
            if (memWait >= MEM_TIMEOUT) begin
                for (int i = 0; i < MEM_TIMEOUT; i++)
                    push(ST_MEMORY, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
                mStat = 3'd3;
                return;
            end
            for (int i = 0; i < memWait; i++)
                push(ST_MEMORY, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
            push(ST_MEMORY, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, de);
            if (de) begin mStat = 3'd3; return; end
        end
        if (ic inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB})
            push(ST_WRITEBACK, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        push(ST_PCUPD, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // ---------------- driver / compare ----------------
    task automatic drive(input rec_t r);
        start       = r.start;
`ifdef SEQ_SINGLE_STEP_EN
        step        = r.step;
`endif
        icode       = r.icode;
        instr_valid = r.valid;
        imem_error  = r.imemErr;
        mem_ready   = r.memReady;
        dmem_error  = r.dmemErr;
    endtask

    task automatic checkRec(input int idx, input rec_t r);
        logic [5:0] expEn;
        expEn = {r.stage == ST_FETCH, r.stage == ST_DECODE, r.stage == ST_EXECUTE,
                 r.stage == ST_MEMORY, r.stage == ST_WRITEBACK, r.stage == ST_PCUPD};
        check($sformatf("c%0d_enables", idx),
              64'({fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_update_en}),
              64'(expEn));
        check($sformatf("c%0d_stat", idx),   64'(stat),        64'(r.stat));
        check($sformatf("c%0d_halted", idx), 64'(halted),      64'(r.stage == ST_HALT));
        check($sformatf("c%0d_cycles", idx), 64'(cycle_count), 64'(r.cyc));
        check($sformatf("c%0d_instrs", idx), 64'(instr_count), 64'(r.ins));
        if (memory_en)    memSeen++;
        if (writeback_en) wbSeen++;
        if (decode_en)    decSeen++;
        if (pc_update_en) pcSeen++;
    endtask

    // Called at a falling edge: check the current cycle, drive its inputs,
    // then advance one full cycle.
    task automatic runRange(input int from, input int to);
        for (int i = from; i < to; i++) begin
            checkRec(i, q[i]);
            drive(q[i]);
            @(negedge clk);
        end
    endtask

    task automatic doReset(input int n);
        reset       = 1'b1;
        start       = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step        = 1'b0;
`endif
        icode       = 4'h0;
        instr_valid = 1'b0;
        imem_error  = 1'b0;
        dmem_error  = 1'b0;
        mem_ready   = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // 1: OPq, mrmovq with 3 wait cycles, rmmovq, jXX, then halt.
        doReset(2);
        beginScenario();
        addIdle(1'b0, 1'b0);
        addIdle(1'b1, 1'b0);
        addInstr(4'h6, 1'b1, 1'b0, 0, 1'b0);
        gap();
        addInstr(4'h5, 1'b1, 1'b0, 3, 1'b0);
        gap();
        addInstr(4'h4, 1'b1, 1'b0, 0, 1'b0);
        gap();
        addInstr(4'h7, 1'b1, 1'b0, 0, 1'b0);
        gap();
        addInstr(4'h0, 1'b1, 1'b0, 0, 1'b0);
        addHalt(4);
        runRange(0, 7);
        check("opq_cycles_after_one", 64'(cycle_count), 64'd5);
        check("opq_instrs_after_one", 64'(instr_count), 64'd1);
        check("opq_stat_aok",         64'(stat),        64'd1);
        runRange(7, q.size());
        check("mix_mem_cycles",  64'(memSeen),     64'd5);
        check("mix_wb_cycles",   64'(wbSeen),      64'd2);
        check("mix_pc_updates",  64'(pcSeen),      64'd4);
        check("mix_final_stat",  64'(stat),        64'd2);
        check("mix_final_cyc",   64'(cycle_count), 64'd24);
        check("mix_final_instr", 64'(instr_count), 64'd4);

        // 2: illegal instruction at fetch.
        doReset(2);
        beginScenario();
        addIdle(1'b0, 1'b0);
        addIdle(1'b1, 1'b0);
        addInstr(4'h6, 1'b0, 1'b0, 0, 1'b0);
        addHalt(3);
        runRange(0, q.size());
        check("ins_stat",      64'(stat),    64'd4);
        check("ins_no_decode", 64'(decSeen), 64'd0);

        // 3: memory never ready -> timeout.
        doReset(2);
        beginScenario();
        addIdle(1'b0, 1'b0);
        addIdle(1'b1, 1'b0);
        addInstr(4'h3, 1'b1, 1'b0, 0, 1'b0);
        gap();
        addInstr(4'h9, 1'b1, 1'b0, 100, 1'b0);
        addHalt(3);
        runRange(0, q.size());
        check("timeout_mem_cycles", 64'(memSeen), 64'd8);
        check("timeout_stat",       64'(stat),    64'd3);

        // 4: data-memory error after one wait cycle.
        doReset(2);
        beginScenario();
        addIdle(1'b1, 1'b0);
        addInstr(4'hA, 1'b1, 1'b0, 1, 1'b1);
        addHalt(2);
        runRange(0, q.size());
        check("dmem_stat",       64'(stat),    64'd3);
        check("dmem_no_wb",      64'(wbSeen),  64'd0);

        // 5: instruction-memory error outranks invalid/halt flags.
        doReset(1);
        beginScenario();
        addIdle(1'b1, 1'b0);
        addInstr(4'h0, 1'b0, 1'b1, 0, 1'b0);
        addHalt(2);
        runRange(0, q.size());
        check("imem_stat", 64'(stat), 64'd3);

        // 6: reset while waiting in MEMORY.
        doReset(1);
        beginScenario();
        addIdle(1'b0, 1'b0);
        addIdle(1'b1, 1'b0);
        addInstr(4'h8, 1'b1, 1'b0, 5, 1'b0);
        runRange(0, 7);
        check("pre_reset_in_memory", 64'(memory_en), 64'd1);
        doReset(1);
        check("rst_enables", 64'({fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_update_en}), 64'd0);
        check("rst_cycles",  64'(cycle_count), 64'd0);
        check("rst_stat",    64'(stat),        64'd1);
        beginScenario();
        addIdle(1'b0, 1'b0);
        addIdle(1'b0, 1'b0);
        runRange(0, q.size());

        // 7: two instructions launched back to back (one pulse each when stepping).
        beginScenario();
        addIdle(1'b0, 1'b0);
        addIdle(1'b1, 1'b0);
        addInstr(4'h1, 1'b1, 1'b0, 0, 1'b0);
        gap();
        addInstr(4'h2, 1'b1, 1'b0, 0, 1'b0);
`ifdef SEQ_SINGLE_STEP_EN
        addIdle(1'b0, 1'b0);
        addIdle(1'b0, 1'b0);
        addIdle(1'b0, 1'b0);
`else
        addInstr(4'h0, 1'b1, 1'b0, 0, 1'b0);
        addHalt(2);
`endif
        runRange(0, q.size());
        check("two_instr_pc_updates", 64'(pcSeen),      64'd2);
        check("two_instr_count",      64'(instr_count), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
